evict_wb_buffer: RTL and testbench

Write-back buffer between the cache control FSM and main memory (mm0). Dirty lines evicted in WR_EVICT/RD_EVICT are pushed here so the FSM can go straight to ALLOC_FILL without waiting for the memory write. The buffer drains entries to main memory in FIFO order over a valid/ready port. It also forwards buffered line data to fills, so a line refetched before it drains returns its newest dirty copy.

---
 rtl/wb_pkg.sv | 27 ++
 rtl/wb_match.sv | 40 ++++
 rtl/evict_wb_buffer.sv | 129 ++++++++++++
 tb/tb_evict_wb_buffer.sv | 284 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/wb_pkg.sv
// Shared types and helpers for the eviction write-back buffer.
// Holds the drain state encoding, the default line geometry and pointer-width helpers.
package wb_pkg;

    localparam int ADDR_W = 32;
    localparam int OFF_W  = 5;
    localparam int LA_W   = ADDR_W - OFF_W;
    localparam int LINE_W = 256;

    typedef enum logic {
        WB_IDLE = 1'b0,
        WB_REQ  = 1'b1
    } wb_state_t;

    function automatic int ptr_w(input int depth);
        return (depth > 1) ? $clog2(depth) : 1;
    endfunction

    // Four-character probe label for the drain state, shown next to the cache FSM decode.
    function automatic logic [31:0] state_name(input wb_state_t s);
        if (s == WB_REQ) begin
            return "REQ ";
        end
        return "IDLE";
    endfunction

endpackage

// File: rtl/wb_match.sv
// Youngest-match selector over the circular entry array of the write-back buffer.
// Entries are scanned oldest to youngest from rd_ptr, so a later match overrides an earlier one.
module wb_match
    import wb_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int KEY_W = 27,
    parameter int PW    = 2
) (
    input  logic [DEPTH-1:0]            valid,
    input  logic [DEPTH-1:0][KEY_W-1:0] la,
    input  logic [PW-1:0]               rd_ptr,
    input  logic [PW-1:0]               wr_ptr,
    input  logic [KEY_W-1:0]            chk_la,
    output logic                        hit,
    output logic [PW-1:0]               sel
);

    logic [PW-1:0] idx;
    logic [PW-1:0] age;
    logic [PW-1:0] span;

    // An equal rd/wr pointer pair means full (or empty, where no valid bit is set).
    always_comb begin
        hit  = 1'b0;
        sel  = '0;
        idx  = '0;
        age  = '0;
        span = wr_ptr - rd_ptr;
        for (int k = 0; k < DEPTH; k++) begin
            idx = rd_ptr + PW'(k);
            age = PW'(k);
            if (valid[idx] && (la[idx] == chk_la) && ((age < span) || (span == '0))) begin
                hit = 1'b1;
                sel = idx;
            end
        end
    end

endmodule

// File: rtl/evict_wb_buffer.sv
// Write-back buffer for evicted dirty lines: FIFO drain to main memory over valid/ready,
// with youngest-copy forwarding to pending fills.
module evict_wb_buffer #(
    parameter int DEPTH  = 4,
    parameter int LINE_W = wb_pkg::LINE_W,
    parameter int ADDR_W = wb_pkg::ADDR_W,
    parameter int OFF_W  = wb_pkg::OFF_W
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic                        evict_valid,
    output logic                        evict_ready,
    input  logic [ADDR_W-OFF_W-1:0]     evict_la,
    input  logic [LINE_W-1:0]           evict_data,
    input  logic [ADDR_W-OFF_W-1:0]     chk_la,
    output logic                        chk_hit,
    output logic [LINE_W-1:0]           chk_data,
    output logic                        mm_wr_valid,
    input  logic                        mm_wr_ready,
    output logic [ADDR_W-OFF_W-1:0]     mm_wr_la,
    output logic [LINE_W-1:0]           mm_wr_data,
    output logic [$clog2(DEPTH+1)-1:0]  count,
    output logic                        empty
);

    import wb_pkg::*;

    localparam int LAW = ADDR_W - OFF_W;
    localparam int PW  = ptr_w(DEPTH);
    localparam int CW  = $clog2(DEPTH + 1);

    wb_state_t                    state;
    wb_state_t                    state_next;
    logic [PW-1:0]                rd_ptr;
    logic [PW-1:0]                wr_ptr;
    logic [CW-1:0]                cnt;
    logic [CW-1:0]                cnt_next;
    logic [DEPTH-1:0]             entry_valid;
    logic [DEPTH-1:0][LAW-1:0]    entry_la;
    logic [DEPTH-1:0][LINE_W-1:0] entry_data;
    logic                         push;
    logic                         pop;
    logic                         hit;
    logic [PW-1:0]                sel;

    // Acceptance looks only at registered occupancy, never at a same-cycle pop.
    assign evict_ready = (cnt < CW'(DEPTH));
    assign push        = evict_valid & evict_ready;
    assign pop         = (state == WB_REQ) & mm_wr_ready;
    assign count       = cnt;
    assign empty       = (cnt == '0);

    always_comb begin
        cnt_next = cnt;
        if (push && !pop) begin
            cnt_next = cnt + CW'(1);
        end else if (!push && pop) begin
            cnt_next = cnt - CW'(1);
        end
    end

    always_comb begin
        state_next  = state;
        mm_wr_valid = 1'b0;
        case (state)
            WB_IDLE: begin
                if (cnt != '0) begin
                    state_next = WB_REQ;
                end
            end
            WB_REQ: begin
                mm_wr_valid = 1'b1;
                if (pop && (cnt_next == '0)) begin
                    state_next = WB_IDLE;
                end
            end
            default: state_next = WB_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= WB_IDLE;
            rd_ptr      <= '0;
            wr_ptr      <= '0;
            cnt         <= '0;
            entry_valid <= '0;
        end else begin
            state <= state_next;
            cnt   <= cnt_next;
            if (push) begin
                wr_ptr              <= wr_ptr + PW'(1);
                entry_valid[wr_ptr] <= 1'b1;
            end
            if (pop) begin
                rd_ptr              <= rd_ptr + PW'(1);
                entry_valid[rd_ptr] <= 1'b0;
            end
        end
    end

    // Line payload is qualified by entry_valid, so it carries no reset.
    always_ff @(posedge clk) begin
        if (push) begin
            entry_la[wr_ptr]   <= evict_la;
            entry_data[wr_ptr] <= evict_data;
        end
    end

    wb_match #(
        .DEPTH (DEPTH),
        .KEY_W (LAW),
        .PW    (PW)
    ) u_match (
        .valid  (entry_valid),
        .la     (entry_la),
        .rd_ptr (rd_ptr),
        .wr_ptr (wr_ptr),
        .chk_la (chk_la),
        .hit    (hit),
        .sel    (sel)
    );

    assign chk_hit    = hit;
    assign chk_data   = hit ? entry_data[sel] : '0;
    assign mm_wr_la   = mm_wr_valid ? entry_la[rd_ptr] : '0;
    assign mm_wr_data = mm_wr_valid ? entry_data[rd_ptr] : '0;

endmodule

// File: tb/tb_evict_wb_buffer.sv
// Directed bench for evict_wb_buffer: reset, single drain, fill/backpressure,
// forwarding, randomised wrap-around with a scoreboard, and reset mid-drain.
`timescale 1ns/1ps
module tb_evict_wb_buffer;

    localparam int DEPTH  = 4;
    localparam int LINE_W = 256;
    localparam int LAW    = 27;
    localparam int CW     = 3;

    logic              clk = 1'b0;
    logic              reset;
    logic              evict_valid;
    logic              evict_ready;
    logic [LAW-1:0]    evict_la;
    logic [LINE_W-1:0] evict_data;
    logic [LAW-1:0]    chk_la;
    logic              chk_hit;
    logic [LINE_W-1:0] chk_data;
    logic              mm_wr_valid;
    logic              mm_wr_ready;
    logic [LAW-1:0]    mm_wr_la;
    logic [LINE_W-1:0] mm_wr_data;
    logic [CW-1:0]     count;
    logic              empty;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    evict_wb_buffer #(
        .DEPTH  (DEPTH),
        .LINE_W (LINE_W),
        .ADDR_W (32),
        .OFF_W  (5)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .evict_valid (evict_valid),
        .evict_ready (evict_ready),
        .evict_la    (evict_la),
        .evict_data  (evict_data),
        .chk_la      (chk_la),
        .chk_hit     (chk_hit),
        .chk_data    (chk_data),
        .mm_wr_valid (mm_wr_valid),
        .mm_wr_ready (mm_wr_ready),
        .mm_wr_la    (mm_wr_la),
        .mm_wr_data  (mm_wr_data),
        .count       (count),
        .empty       (empty)
    );

    function automatic logic [LINE_W-1:0] mk_line(input logic [31:0] base);
        logic [LINE_W-1:0] l;
        l = '0;
        for (int i = 0; i < 8; i++) begin
            l[32*i +: 32] = base + 32'(i);
        end
        return l;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        reset       = 1'b1;
        evict_valid = 1'b0;
        evict_la    = '0;
        evict_data  = '0;
        chk_la      = '0;
        mm_wr_ready = 1'b1;
        tick();
        tick();
        reset = 1'b0;
        checks++; if (chk_hit !== 1'b0) begin failures++; $display("FAIL reset_chk_hit: got %0h want 0", chk_hit); end
        checks++; if (chk_data !== '0) begin failures++; $display("FAIL reset_chk_data: got %0h want 0", chk_data); end
        checks++; if (mm_wr_la !== '0) begin failures++; $display("FAIL reset_mm_wr_la: got %0h want 0", mm_wr_la); end
        checks++; if (mm_wr_data !== '0) begin failures++; $display("FAIL reset_mm_wr_data: got %0h want 0", mm_wr_data); end
        for (int c = 0; c < 10; c++) begin
            checks++; if (evict_ready !== 1'b1) begin failures++; $display("FAIL idle_evict_ready c=%0d: got %0h want 1", c, evict_ready); end
            checks++; if (empty !== 1'b1) begin failures++; $display("FAIL idle_empty c=%0d: got %0h want 1", c, empty); end
            checks++; if (count !== 3'd0) begin failures++; $display("FAIL idle_count c=%0d: got %0d want 0", c, count); end
            checks++; if (mm_wr_valid !== 1'b0) begin failures++; $display("FAIL idle_mm_wr_valid c=%0d: got %0h want 0", c, mm_wr_valid); end
            tick();
        end
    endtask

    task automatic test_single();
        mm_wr_ready = 1'b1;
        evict_valid = 1'b1;
        evict_la    = 27'h0000010;
        evict_data  = mk_line(32'hA0);
        checks++; if (evict_ready !== 1'b1) begin failures++; $display("FAIL single_ready: got %0h want 1", evict_ready); end
        tick();
        evict_valid = 1'b0;
        checks++; if (count !== 3'd1) begin failures++; $display("FAIL single_count_n1: got %0d want 1", count); end
        checks++; if (mm_wr_valid !== 1'b0) begin failures++; $display("FAIL single_valid_n1: got %0h want 0", mm_wr_valid); end
        tick();
        checks++; if (mm_wr_valid !== 1'b1) begin failures++; $display("FAIL single_valid_n2: got %0h want 1", mm_wr_valid); end
        checks++; if (mm_wr_la !== 27'h0000010) begin failures++; $display("FAIL single_la: got %0h want 10", mm_wr_la); end
        checks++; if (mm_wr_data !== mk_line(32'hA0)) begin failures++; $display("FAIL single_data: got %0h want %0h", mm_wr_data, mk_line(32'hA0)); end
        tick();
        checks++; if (mm_wr_valid !== 1'b0) begin failures++; $display("FAIL single_valid_n3: got %0h want 0", mm_wr_valid); end
        checks++; if (empty !== 1'b1) begin failures++; $display("FAIL single_empty_n3: got %0h want 1", empty); end
    endtask

    task automatic test_fill();
        logic [CW-1:0] exp_cnt [5];
        exp_cnt[0] = 3'd4; exp_cnt[1] = 3'd3; exp_cnt[2] = 3'd3; exp_cnt[3] = 3'd2; exp_cnt[4] = 3'd1;
        mm_wr_ready = 1'b0;
        for (int k = 0; k < 4; k++) begin
            evict_valid = 1'b1;
            evict_la    = 27'h100 + 27'(k);
            evict_data  = mk_line(32'h1000 + 32'(16 * k));
            tick();
        end
        evict_la   = 27'h104;
        evict_data = mk_line(32'h1040);
        checks++; if (count !== 3'd4) begin failures++; $display("FAIL fill_count: got %0d want 4", count); end
        checks++; if (evict_ready !== 1'b0) begin failures++; $display("FAIL fill_ready: got %0h want 0", evict_ready); end
        for (int c = 0; c < 3; c++) begin
            tick();
            checks++; if (count !== 3'd4) begin failures++; $display("FAIL full_hold_count c=%0d: got %0d want 4", c, count); end
            checks++; if (evict_ready !== 1'b0) begin failures++; $display("FAIL full_hold_ready c=%0d: got %0h want 0", c, evict_ready); end
            checks++; if (mm_wr_valid !== 1'b1 || mm_wr_la !== 27'h100) begin failures++; $display("FAIL full_hold_head c=%0d: got v=%0h la=%0h want v=1 la=100", c, mm_wr_valid, mm_wr_la); end
        end
        mm_wr_ready = 1'b1;
        for (int j = 0; j < 5; j++) begin
            checks++; if (mm_wr_valid !== 1'b1) begin failures++; $display("FAIL drain_valid j=%0d: got %0h want 1", j, mm_wr_valid); end
            checks++; if (mm_wr_la !== 27'h100 + 27'(j)) begin failures++; $display("FAIL drain_la j=%0d: got %0h want %0h", j, mm_wr_la, 27'h100 + 27'(j)); end
            checks++; if (mm_wr_data !== mk_line(32'h1000 + 32'(16 * j))) begin failures++; $display("FAIL drain_data j=%0d: got %0h want %0h", j, mm_wr_data, mk_line(32'h1000 + 32'(16 * j))); end
            checks++; if (count !== exp_cnt[j]) begin failures++; $display("FAIL drain_count j=%0d: got %0d want %0d", j, count, exp_cnt[j]); end
            if (j == 1) begin
                checks++; if (evict_ready !== 1'b1) begin failures++; $display("FAIL held_accept_ready: got %0h want 1", evict_ready); end
            end
            tick();
            if (j == 1) evict_valid = 1'b0;
        end
        checks++; if (mm_wr_valid !== 1'b0) begin failures++; $display("FAIL drain_done_valid: got %0h want 0", mm_wr_valid); end
        checks++; if (empty !== 1'b1) begin failures++; $display("FAIL drain_done_empty: got %0h want 1", empty); end
    endtask

    task automatic test_forward();
        mm_wr_ready = 1'b0;
        evict_valid = 1'b1;
        evict_la    = 27'h20;
        evict_data  = mk_line(32'hA000);
        chk_la      = 27'h20;
        #1;
        checks++; if (chk_hit !== 1'b0) begin failures++; $display("FAIL fwd_same_cycle_push: got %0h want 0", chk_hit); end
        tick();
        evict_data = mk_line(32'hB000);
        #1;
        checks++; if (chk_hit !== 1'b1 || chk_data !== mk_line(32'hA000)) begin failures++; $display("FAIL fwd_single_copy: got hit=%0h data=%0h want hit=1 data=%0h", chk_hit, chk_data, mk_line(32'hA000)); end
        tick();
        evict_valid = 1'b0;
        #1;
        checks++; if (chk_hit !== 1'b1) begin failures++; $display("FAIL fwd_hit: got %0h want 1", chk_hit); end
        checks++; if (chk_data !== mk_line(32'hB000)) begin failures++; $display("FAIL fwd_youngest: got %0h want %0h", chk_data, mk_line(32'hB000)); end
        chk_la = 27'h21;
        #1;
        checks++; if (chk_hit !== 1'b0) begin failures++; $display("FAIL fwd_miss_hit: got %0h want 0", chk_hit); end
        checks++; if (chk_data !== '0) begin failures++; $display("FAIL fwd_miss_data: got %0h want 0", chk_data); end
        chk_la      = 27'h20;
        mm_wr_ready = 1'b1;
        #1;
        checks++; if (mm_wr_valid !== 1'b1 || mm_wr_data !== mk_line(32'hA000)) begin failures++; $display("FAIL fwd_head_a: got v=%0h data=%0h want v=1 data=%0h", mm_wr_valid, mm_wr_data, mk_line(32'hA000)); end
        checks++; if (chk_hit !== 1'b1 || chk_data !== mk_line(32'hB000)) begin failures++; $display("FAIL fwd_during_pop: got hit=%0h data=%0h want hit=1 data=%0h", chk_hit, chk_data, mk_line(32'hB000)); end
        tick();
        checks++; if (mm_wr_valid !== 1'b1 || mm_wr_la !== 27'h20 || mm_wr_data !== mk_line(32'hB000)) begin failures++; $display("FAIL fwd_head_b: got v=%0h la=%0h data=%0h want v=1 la=20 data=%0h", mm_wr_valid, mm_wr_la, mm_wr_data, mk_line(32'hB000)); end
        checks++; if (chk_hit !== 1'b1 || chk_data !== mk_line(32'hB000)) begin failures++; $display("FAIL fwd_last_copy: got hit=%0h data=%0h want hit=1 data=%0h", chk_hit, chk_data, mk_line(32'hB000)); end
        tick();
        checks++; if (chk_hit !== 1'b0 || chk_data !== '0) begin failures++; $display("FAIL fwd_after_drain: got hit=%0h data=%0h want hit=0 data=0", chk_hit, chk_data); end
        checks++; if (empty !== 1'b1) begin failures++; $display("FAIL fwd_empty: got %0h want 1", empty); end
    endtask

    task automatic test_wrap();
        logic [LAW-1:0]    q_la[$];
        logic [LINE_W-1:0] q_data[$];
        logic [LAW-1:0]    prev_la;
        logic [LINE_W-1:0] prev_data;
        logic              stalled;
        int                pushed;
        int                popped;
        int                cyc;
        pushed  = 0;
        popped  = 0;
        cyc     = 0;
        stalled = 1'b0;
        prev_la = '0;
        prev_data = '0;
        while (popped < 10 && cyc < 400) begin
            evict_valid = (pushed < 10) && ($urandom_range(0, 1) == 1);
            evict_la    = 27'h300 + 27'(pushed);
            evict_data  = mk_line(32'h5000 + 32'(pushed * 7));
            mm_wr_ready = ($urandom_range(0, 1) == 1);
            #1;
            checks++; if (count !== CW'(q_la.size())) begin failures++; $display("FAIL wrap_count cyc=%0d: got %0d want %0d", cyc, count, q_la.size()); end
            checks++; if (count > 3'd4) begin failures++; $display("FAIL wrap_count_bound cyc=%0d: got %0d want <=4", cyc, count); end
            if (stalled) begin
                checks++; if (mm_wr_valid !== 1'b1 || mm_wr_la !== prev_la || mm_wr_data !== prev_data) begin failures++; $display("FAIL wrap_stable cyc=%0d: got v=%0h la=%0h want v=1 la=%0h", cyc, mm_wr_valid, mm_wr_la, prev_la); end
            end
            if (mm_wr_valid && mm_wr_ready) begin
                if (q_la.size() == 0) begin
                    checks++; failures++; $display("FAIL wrap_pop_empty cyc=%0d: got write la=%0h want none", cyc, mm_wr_la);
                end else begin
                    checks++; if (mm_wr_la !== q_la[0] || mm_wr_data !== q_data[0]) begin failures++; $display("FAIL wrap_order cyc=%0d: got la=%0h want la=%0h", cyc, mm_wr_la, q_la[0]); end
                    void'(q_la.pop_front());
                    void'(q_data.pop_front());
                end
                popped++;
            end
            if (evict_valid && evict_ready) begin
                q_la.push_back(evict_la);
                q_data.push_back(evict_data);
                pushed++;
            end
            stalled   = mm_wr_valid && !mm_wr_ready;
            prev_la   = mm_wr_la;
            prev_data = mm_wr_data;
            tick();
            cyc++;
        end
        checks++; if (popped != 10) begin failures++; $display("FAIL wrap_completion: got %0d writes want 10", popped); end
        evict_valid = 1'b0;
        mm_wr_ready = 1'b1;
        tick();
        tick();
        checks++; if (empty !== 1'b1) begin failures++; $display("FAIL wrap_final_empty: got %0h want 1", empty); end
    endtask

    task automatic test_reset_mid();
        mm_wr_ready = 1'b0;
        for (int k = 0; k < 3; k++) begin
            evict_valid = 1'b1;
            evict_la    = 27'h400 + 27'(k);
            evict_data  = mk_line(32'h4000 + 32'(16 * k));
            tick();
        end
        evict_valid = 1'b0;
        chk_la      = 27'h401;
        #1;
        checks++; if (mm_wr_valid !== 1'b1 || count !== 3'd3) begin failures++; $display("FAIL pre_reset_state: got v=%0h count=%0d want v=1 count=3", mm_wr_valid, count); end
        checks++; if (chk_hit !== 1'b1 || chk_data !== mk_line(32'h4010)) begin failures++; $display("FAIL pre_reset_fwd: got hit=%0h data=%0h want hit=1 data=%0h", chk_hit, chk_data, mk_line(32'h4010)); end
        reset       = 1'b1;
        evict_valid = 1'b1;
        evict_la    = 27'h500;
        mm_wr_ready = 1'b1;
        tick();
        reset       = 1'b0;
        evict_valid = 1'b0;
        #1;
        checks++; if (count !== 3'd0) begin failures++; $display("FAIL mid_reset_count: got %0d want 0", count); end
        checks++; if (mm_wr_valid !== 1'b0) begin failures++; $display("FAIL mid_reset_valid: got %0h want 0", mm_wr_valid); end
        checks++; if (chk_hit !== 1'b0 || chk_data !== '0) begin failures++; $display("FAIL mid_reset_chk: got hit=%0h data=%0h want hit=0 data=0", chk_hit, chk_data); end
        checks++; if (evict_ready !== 1'b1 || empty !== 1'b1) begin failures++; $display("FAIL mid_reset_ready: got ready=%0h empty=%0h want 1/1", evict_ready, empty); end
        checks++; if (mm_wr_la !== '0) begin failures++; $display("FAIL mid_reset_la: got %0h want 0", mm_wr_la); end
        tick();
        tick();
        checks++; if (mm_wr_valid !== 1'b0 || count !== 3'd0) begin failures++; $display("FAIL post_reset_quiet: got v=%0h count=%0d want v=0 count=0", mm_wr_valid, count); end
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        test_reset();
        test_single();
        test_fill();
        test_forward();
        test_wrap();
        test_reset_mid();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
